// File: rtl/seq_detect_param.sv
// seq_detect_param -- configurable serial pattern detector.
//
// A bit stream arrives on `in` (qualified by `en`). Once a pattern has been
// loaded with `cfg_load`, the detector collects PAT_W-1 history bits (FILL)
// and then compares every new bit, together with the history, against the
// latched pattern under a per-bit mask (ARMED). A hit drives `out` in the
// same cycle (Mealy) and `out_q` one cycle later.
//
// Optional feature: define SEQ_DETECT_COUNT_EN to add the saturating match
// counter and its `match_cnt` output port.
//
// Ports:
//   clk          rising-edge clock
//   clr          synchronous active-high reset
//   en           sample-valid for `in`
//   in           serial data bit
//   cfg_load     strobe capturing cfg_pattern / cfg_mask / cfg_overlap
//   cfg_pattern  target sequence, bit PAT_W-1 oldest, bit 0 newest
//   cfg_mask     per-bit compare enable (0 = don't care)
//   cfg_overlap  1 = overlapping matches, 0 = history cleared after a match
//   out          combinational match
//   out_q        `out` delayed by one cycle
//   state        0 IDLE, 1 FILL, 2 ARMED
//   match_cnt    saturating match count (SEQ_DETECT_COUNT_EN only)

module seq_detect_param #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    output logic             out,
    output logic             out_q,
    output logic [1:0]       state
`ifdef SEQ_DETECT_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [1:0]       state_q, state_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] mask_q, mask_d;
    logic             ovl_q, ovl_d;
    logic             out_q_d;

    // Current compare window: history plus the incoming bit as the newest.
    logic [PAT_W-1:0] window;
    logic             hit;

    assign window = {hist_q, in};
    assign hit    = ((window ^ pat_q) & mask_q) == '0;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            mask_q  <= '0;
            ovl_q   <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            out_q   <= out_q_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        out_q_d = out;
        if (cfg_load) begin
            // Load wins over a coincident sample; that sample is dropped.
            state_d = S_FILL;
            hist_d  = '0;
            fill_d  = '0;
            pat_d   = cfg_pattern;
            mask_d  = cfg_mask;
            ovl_d   = cfg_overlap;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_FILL, S_ARMED: begin
                    if (en) begin
                        if (out && !ovl_q) begin
                            // Non-overlapping mode restarts collection.
                            state_d = S_FILL;
                            hist_d  = '0;
                            fill_d  = '0;
                        end else begin
                            hist_d = window[PAT_W-2:0];
                            if (fill_q != FILL_MAX) begin
                                fill_d = fill_q + FILL_W'(1);
                            end
                            if (fill_d == FILL_MAX) begin
                                state_d = S_ARMED;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        out   = !clr && !cfg_load && en && (state_q == S_ARMED) && hit;
        state = state_q;
    end

`ifdef SEQ_DETECT_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (out && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 3, pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, match-counter width, legal range 1..16.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port en  input  1  sample-valid qualifier for in.
REQ-006 The block SHALL have port in  input  1  serial data bit.
REQ-007 The block SHALL have port cfg_load  input  1  one-cycle strobe capturing cfg_pattern, cfg_mask, cfg_overlap.
REQ-008 The block SHALL have port cfg_pattern  input  PAT_W  target sequence; bit PAT_W-1 oldest, bit 0 newest.
REQ-009 The block SHALL have port cfg_mask  input  PAT_W  per-bit compare enable; 0 = don't care.
REQ-010 The block SHALL have port cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match.
REQ-011 The block SHALL have port out  output  1  Mealy match, combinational from state, history and in.
REQ-012 The block SHALL have port out_q  output  1  out registered, one cycle later.
REQ-013 The block SHALL have port state  output  2  FSM state: 0 IDLE, 1 FILL, 2 ARMED.
REQ-014 The block SHALL have port match_cnt  output  CNT_W  saturating match count (present only per REQ-031).

Function
REQ-015 The FSM SHALL hold three states: IDLE (no pattern loaded), FILL (fewer than PAT_W-1 valid history bits), ARMED (at least PAT_W-1 valid history bits); encoding 3 SHALL return to IDLE.
REQ-016 The FSM SHALL move from any state to FILL on cfg_load=1, latching pattern, mask and overlap, and clearing history and fill count.
REQ-017 When cfg_load and en are high in the same cycle, the load SHALL win, in SHALL be discarded, and out SHALL be 0.
REQ-018 In IDLE, en SHALL be ignored, history SHALL stay 0, and out SHALL be 0.
REQ-019 In FILL or ARMED with en=1, history SHALL shift left with in entering bit 0; fill count SHALL increment, saturating at PAT_W-1.
REQ-020 The FSM SHALL move from FILL to ARMED on the en=1 cycle that brings the fill count to PAT_W-1.
REQ-021 out SHALL be 1 iff state=ARMED, en=1, cfg_load=0, and ({hist[PAT_W-2:0], in} & mask) == (pattern & mask).
REQ-022 With en=0, history, fill count and state SHALL hold, and out SHALL be 0.
REQ-023 On a match with overlap=1, history SHALL shift normally and the state SHALL remain ARMED.
REQ-024 On a match with overlap=0, history and fill count SHALL clear and the state SHALL go to FILL.
REQ-025 With mask all-zero in ARMED, every en=1 cycle SHALL match, subject to REQ-024.
REQ-026 out_q SHALL equal the previous cycle's out; latency from in to out_q SHALL be 1 cycle.
REQ-027 Changes on cfg_pattern, cfg_mask or cfg_overlap without cfg_load SHALL have no effect.

Reset
REQ-028 clr=1 at a rising edge SHALL set state=IDLE, history=0, fill count=0, latched pattern/mask/overlap=0, out_q=0, match_cnt=0, overriding cfg_load and en.
REQ-029 out SHALL be 0 during any cycle with clr=1.
REQ-030 clr asserted mid-sequence SHALL discard partial history; detection SHALL resume only after a new cfg_load.

Configuration
REQ-031 Macro SEQ_DETECT_COUNT_EN defined: match_cnt SHALL increment by 1 on each cycle with out=1, saturate at 2^CNT_W-1, and clear on clr or cfg_load. Undefined: port match_cnt, the counter and its logic SHALL be absent.

Verification
REQ-032 PAT_W=3, load pattern 3'b001, mask 3'b011, overlap=1; en=1, in stream 0,0,1,1,0,1 -> out=1 on the 3rd and 6th bits only; out_q 1 cycle later.
REQ-033 PAT_W=4, pattern 4'b1010, mask 4'b1111, overlap=1; stream 1,0,1,0,1,0 -> out on bits 4 and 6; same with overlap=0 -> out on bit 4 only.
REQ-034 Stream 0,0 with en=0 on a cycle between the bits, then 1 -> gap ignored, out=1 on the 1; cfg_load with en in the same cycle -> that bit discarded, state=FILL.
REQ-035 clr pulsed after two of three pattern bits -> state=IDLE, out=0 on the next bit; no match until reload.
REQ-036 With SEQ_DETECT_COUNT_EN, CNT_W=2, mask=0, overlap=1, 6 en cycles after arming -> match_cnt reads 1,2,3,3,3,3.
